prime_collector: RTL and testbench

PRIME_COLLECTOR -- requirements
Module: prime_collector

---
 rtl/prime_collector.sv | 114 +++++++++++
 tb/tb_prime_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/prime_collector.sv
// prime_collector
//   Collects prime values reported by an upstream checker into a
//   first-word-fall-through FIFO and keeps running statistics on the
//   prime stream.
//
// Ports
//   SysClk        : system clock, all state updates on the rising edge
//   Reset         : asynchronous, active-low reset
//   Prime         : qualifies NumberChecked as a prime
//   NumberChecked : candidate value from upstream (unsigned, 10 bits)
//   RdEn          : consumer pop request (ignored when Empty)
//   PrimeOut      : oldest stored prime, 0 when Empty
//   Empty / Full  : FIFO occupancy flags
//   Count         : current occupancy, 0..DEPTH
//   Dropped       : primes lost to overflow, saturating at 255
//   TwinCount     : twin-prime pairs seen (gap of 2), saturating at 255
//   MaxGap        : largest rising gap between consecutive accepted primes
//   LastPrime     : most recent prime event value, 0 before any
module prime_collector #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     SysClk,
  input  logic                     Reset,
  input  logic                     Prime,
  input  logic [9:0]               NumberChecked,
  input  logic                     RdEn,
  output logic [9:0]               PrimeOut,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic [7:0]               Dropped,
  output logic [7:0]               TwinCount,
  output logic [9:0]               MaxGap,
  output logic [9:0]               LastPrime
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          seen;
  logic [7:0]    dropped;
  logic [7:0]    twin_count;
  logic [9:0]    max_gap;
  logic [9:0]    last_prime;

  logic          prime_event;
  logic          pop;
  logic          push;
  logic          rising;
  logic [9:0]    gap;

  always_comb begin
    // A held Prime on an unchanged value is one event; the very first
    // prime after reset always counts even if it equals the cleared LastPrime.
    prime_event = Prime && (!seen || (NumberChecked != last_prime));
    pop         = RdEn && (count != '0);
    // A same-edge pop frees a slot, so a write at Full is still accepted.
    push        = prime_event && ((count != FULL_LVL) || pop);
    // Gap statistics only apply to an upward step from a previous prime;
    // a downward step is an upstream restart.
    rising      = prime_event && seen && (NumberChecked > last_prime);
    gap         = NumberChecked - last_prime;
  end

  always_ff @(posedge SysClk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      seen       <= 1'b0;
      dropped    <= '0;
      twin_count <= '0;
      max_gap    <= '0;
      last_prime <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (prime_event) begin
        seen       <= 1'b1;
        last_prime <= NumberChecked;
        if (!push && (dropped != '1)) dropped <= dropped + 1'b1;
      end

      if (rising) begin
        if (gap > max_gap) max_gap <= gap;
        if ((gap == 10'd2) && (twin_count != '1)) twin_count <= twin_count + 1'b1;
      end
    end
  end

  // Storage needs no reset: the cleared pointers and count make old
  // contents unreachable.
  always_ff @(posedge SysClk) begin
    if (push) mem[wr_ptr] <= NumberChecked;
  end

  assign Empty     = (count == '0);
  assign Full      = (count == FULL_LVL);
  assign Count     = count;
  assign PrimeOut  = Empty ? '0 : mem[rd_ptr];
  assign Dropped   = dropped;
  assign TwinCount = twin_count;
  assign MaxGap    = max_gap;
  assign LastPrime = last_prime;

endmodule

// File: tb/tb_prime_collector.sv
// Testbench for prime_collector: directed vectors, a queue-based reference
// model checked on every falling edge, and literal expectations for the
// key scenarios.
module tb_prime_collector;

  localparam int unsigned DEPTH = 16;

  logic        SysClk;
  logic        Reset;
  logic        Prime;
  logic [9:0]  NumberChecked;
  logic        RdEn;
  logic [9:0]  PrimeOut;
  logic        Empty;
  logic        Full;
  logic [4:0]  Count;
  logic [7:0]  Dropped;
  logic [7:0]  TwinCount;
  logic [9:0]  MaxGap;
  logic [9:0]  LastPrime;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_q[$];
  bit m_seen;
  int m_last, m_maxgap, m_twin, m_drop;

  prime_collector #(.DEPTH(DEPTH)) dut (
    .SysClk(SysClk), .Reset(Reset), .Prime(Prime), .NumberChecked(NumberChecked),
    .RdEn(RdEn), .PrimeOut(PrimeOut), .Empty(Empty), .Full(Full), .Count(Count),
    .Dropped(Dropped), .TwinCount(TwinCount), .MaxGap(MaxGap), .LastPrime(LastPrime)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_seen = 0; m_last = 0; m_maxgap = 0; m_twin = 0; m_drop = 0;
  endtask

  task automatic model_edge(input bit p, input int n, input bit r);
    bit was_full, do_pop, ev;
    was_full = (m_q.size() == DEPTH);
    do_pop   = r && (m_q.size() > 0);
    ev       = p && (!m_seen || n != m_last);
    if (do_pop) void'(m_q.pop_front());
    if (ev) begin
      if (!was_full || do_pop) m_q.push_back(n);
      else if (m_drop < 255) m_drop++;
      if (m_seen && n > m_last) begin
        if (n - m_last > m_maxgap) m_maxgap = n - m_last;
        if (n - m_last == 2 && m_twin < 255) m_twin++;
      end
      m_last = n;
      m_seen = 1;
    end
  endtask

  // Called at posedge+2; applies inputs across one rising edge.
  task automatic step(input bit p, input int n, input bit r);
    Prime = p; NumberChecked = n[9:0]; RdEn = r;
    @(posedge SysClk);
    model_edge(p, n, r);
    #2;
  endtask

  task automatic do_reset();
    Prime = 0; RdEn = 0; NumberChecked = '0;
    Reset = 0;
    model_clear();
    repeat (2) @(posedge SysClk);
    #2 Reset = 1;
  endtask

  // Full comparison against the model on every falling edge.
  always @(negedge SysClk) begin
    check("PrimeOut",  int'(PrimeOut),  m_q.size() > 0 ? m_q[0] : 0);
    check("Empty",     int'(Empty),     m_q.size() == 0 ? 1 : 0);
    check("Full",      int'(Full),      m_q.size() == DEPTH ? 1 : 0);
    check("Count",     int'(Count),     m_q.size());
    check("Dropped",   int'(Dropped),   m_drop);
    check("TwinCount", int'(TwinCount), m_twin);
    check("MaxGap",    int'(MaxGap),    m_maxgap);
    check("LastPrime", int'(LastPrime), m_last);
  end

  initial begin
    int primes[6] = '{2, 3, 5, 7, 11, 13};
    Prime = 0; RdEn = 0; NumberChecked = '0; Reset = 0;
    model_clear();
    repeat (2) @(posedge SysClk);
    #2 Reset = 1;

    // reset then idle
    repeat (3) step(0, 0, 0);
    check("rst_empty", int'(Empty), 1);
    check("rst_full",  int'(Full), 0);
    check("rst_count", int'(Count), 0);
    check("rst_out",   int'(PrimeOut), 0);
    check("rst_drop",  int'(Dropped), 0);
    check("rst_twin",  int'(TwinCount), 0);
    check("rst_gap",   int'(MaxGap), 0);
    check("rst_last",  int'(LastPrime), 0);
    // RdEn on empty FIFO is ignored
    step(0, 0, 1);
    check("rd_empty_count", int'(Count), 0);

    // six small primes
    foreach (primes[i]) step(1, primes[i], 0);
    step(0, 0, 0);
    check("six_count", int'(Count), 6);
    check("six_out",   int'(PrimeOut), 2);
    check("six_twin",  int'(TwinCount), 3);
    check("six_gap",   int'(MaxGap), 4);
    check("six_last",  int'(LastPrime), 13);

    // held prime is one event
    repeat (5) step(1, 17, 0);
    step(0, 0, 0);
    check("hold_count", int'(Count), 7);
    check("hold_last",  int'(LastPrime), 17);

    // overflow with 18 events, then drain
    do_reset();
    for (int i = 0; i < 18; i++) step(1, 100 + i, 0);
    step(0, 0, 0);
    check("ovf_full",  int'(Full), 1);
    check("ovf_count", int'(Count), 16);
    check("ovf_drop",  int'(Dropped), 2);
    for (int i = 0; i < 16; i++) begin
      check("drain_out", int'(PrimeOut), 100 + i);
      step(0, 0, 1);
    end
    check("drain_empty", int'(Empty), 1);
    check("drain_out0",  int'(PrimeOut), 0);

    // write at Full with same-edge pop
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 200 + i, 0);
    step(1, 101, 1);
    step(0, 0, 0);
    check("fullrw_count", int'(Count), 16);
    check("fullrw_drop",  int'(Dropped), 0);
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    check("fullrw_lastout", int'(PrimeOut), 101);
    step(0, 0, 1);
    check("fullrw_empty", int'(Empty), 1);

    // simultaneous write and pop at Count=1
    step(1, 300, 0);
    step(1, 301, 1);
    check("one_rw_count", int'(Count), 1);
    check("one_rw_out",   int'(PrimeOut), 301);

    // restart handling, then mid-stream reset
    do_reset();
    step(1, 97, 0);
    step(1, 101, 0);
    step(1, 2, 0);
    step(1, 3, 0);
    step(0, 0, 0);
    check("rs_gap",  int'(MaxGap), 4);
    check("rs_twin", int'(TwinCount), 0);
    check("rs_last", int'(LastPrime), 3);
    step(1, 5, 1);
    Prime = 0; RdEn = 0;
    Reset = 0;
    model_clear();
    #1;
    check("async_count", int'(Count), 0);
    check("async_empty", int'(Empty), 1);
    check("async_out",   int'(PrimeOut), 0);
    check("async_last",  int'(LastPrime), 0);
    check("async_gap",   int'(MaxGap), 0);
    repeat (2) @(posedge SysClk);
    #2 Reset = 1;

    // saturation of Dropped and TwinCount
    for (int i = 1; i <= 511; i++) step(1, 2 * i, 0);
    step(0, 0, 0);
    check("sat_drop",  int'(Dropped), 255);
    check("sat_twin",  int'(TwinCount), 255);
    check("sat_gap",   int'(MaxGap), 2);
    check("sat_count", int'(Count), 16);
    check("sat_last",  int'(LastPrime), 1022);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
